inst_queue: RTL
===============

Name: inst_queue

Overview:
- Decoupling FIFO between the fetch stage (pc/IF) and the decode stage (ID).
- Buffers fetched instruction packets (pc, inst, delay-slot flag, exception vector, has-exc flag) so that ID stalls need not back-pressure the icache every cycle.
- A fetch that completes during an ID stall is never lost.
- Flushed on exception/eret redirects and on mispredicted-branch recovery from the controller.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- flush_i  input  1  from controller; discard all queued entries
- in_valid_i  input  1  IF presents a valid packet (pcvalid and not flushed)
- in_pc_i  input  32  fetched PC
- in_inst_i  input  32  fetched instruction word
- in_inslot_i  input  1  packet is a branch delay slot
- in_excs_i  input  `ExcE_W  exception vector from IF
- in_has_exc_i  input  1  any exception pending on packet
- in_ready_o  input-side  output  1  queue can accept this cycle; drives the IF stall request
- out_valid_o  output  1  head entry valid for ID
- out_ready_i  input  1  ID consumes head this cycle
- out_pc_o  output  32  head PC
- out_inst_o  output  32  head instruction
- out_inslot_o  output  1  head delay-slot flag
- out_excs_o  output  `ExcE_W  head exception vector
- out_has_exc_o  output  1  head has-exception flag
- count_o  output  PTR_W+1  current occupancy, for the perf counter and debug

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All entry storage cleared to 0, so every out_* data output reads 0.
  - out_valid_o=0, in_ready_o=1.
- Storage: DEPTH-entry register array. Each entry is {pc, inst, inslot, excs, has_exc}. Pointers wrap modulo DEPTH (natural PTR_W overflow).
- in_ready_o = (count != DEPTH) & !flush_i. This is purely combinational from the count register and flush_i.
- out_valid_o = (count != 0) & !flush_i.
- out_* data outputs come combinationally from array[rd_ptr]; they are stable while out_valid_o=1 and out_ready_i=0.
- Push = in_valid_i & in_ready_o.
  - Writes array[wr_ptr]; wr_ptr += 1 at the next edge.
- Pop = out_valid_o & out_ready_i.
  - rd_ptr += 1 at the next edge.
- Count update: push only → +1; pop only → -1; both → unchanged.
- Latency: no bypass. A packet pushed in cycle N is first visible at the head in cycle N+1.
- Full (count==DEPTH): in_ready_o=0 even if a pop occurs that same cycle; no push-through. Push is accepted the cycle after the pop.
- Empty (count==0): out_valid_o=0; out_ready_i is ignored; data outputs hold their stale values.
- Flush has priority over push and pop in the same cycle.
  - Next edge: wr_ptr=rd_ptr=0, count=0.
  - Entry contents need not be cleared.
  - The same-cycle push and pop are both dropped.
- flush_i asserted for several consecutive cycles: queue stays empty throughout; in_ready_o=0 and out_valid_o=0.
- The delay-slot flag is carried per entry unchanged; the queue never separates a branch from its slot except on flush.
- count never exceeds DEPTH and never underflows. Bench assertion: a pop with count==0, or a push with count==DEPTH, is a fatal error.

Decomposition:
- ExcE_W, the ExcE range and the packet field widths stay in the shared defines.v.
- Add an `IQ_ENTRY_W constant there (32+32+1+ExcE_W+1).
- One natural sub-module: iq_ram, a DEPTH x `IQ_ENTRY_W register array with async clear, one write port and one async read port.
- Pointer and count logic stays in inst_queue.

Test Plan:
- Reset then idle → out_valid_o=0, in_ready_o=1, count_o=0, out_pc_o=0.
- Push pc 0xbfc00000, 0xbfc00004, 0xbfc00008, 0xbfc0000c with out_ready_i=0 → count_o=4, in_ready_o=0; a 5th push (pc 0xbfc00010) is not accepted. Then raise out_ready_i → PCs drain in order; the 5th is accepted in the cycle after the first pop.
- Continuous push and pop for 10 packets → count_o stays 1 after the first cycle; PCs exit in order with one-cycle latency; pointers wrap cleanly past entry 3.
- Queue holding 3 entries; flush_i=1 together with in_valid_i=1 (pc 0xbfc00380) and out_ready_i=1 → next cycle count_o=0 and out_valid_o=0; pc 0xbfc00380 never appears at the output.
- Push a branch (inslot=0) then its delay slot (inslot=1, excs[1]=1, has_exc=1, pc 0xbfc00006) → outputs reproduce every field bit-exact in order.
- Assert rst_n=0 mid-operation with 2 entries queued → out_valid_o drops immediately (asynchronously); after release, count_o=0.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared packet widths and queue entry layout for the IF->ID instruction queue
package inst_queue_pkg;
  localparam int EXCE_W = 16;
  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              inslot;
    logic [EXCE_W-1:0] excs;
    logic              has_exc;
  } iq_entry_t;
  localparam int IQ_ENTRY_W = $bits(iq_entry_t);
endpackage

// File: rtl/iq_ram.sv
// iq_ram: DEPTH x IQ_ENTRY_W register array, async clear, one write port, one async read port
module iq_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [IQ_ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [IQ_ENTRY_W-1:0] rdata
);
  logic [IQ_ENTRY_W-1:0] mem [DEPTH];
  // entries clear on reset so the head reads zero until the first fetch lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_queue.sv
// inst_queue: decoupling FIFO between fetch and decode, flushed on redirects
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [31:0]       in_pc_i,
  input  logic [31:0]       in_inst_i,
  input  logic              in_inslot_i,
  input  logic [EXCE_W-1:0] in_excs_i,
  input  logic              in_has_exc_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_pc_o,
  output logic [31:0]       out_inst_o,
  output logic              out_inslot_o,
  output logic [EXCE_W-1:0] out_excs_o,
  output logic              out_has_exc_o,
  output logic [PTR_W:0]    count_o
);
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop;
  iq_entry_t        wr_entry, rd_entry;

  // no push-through when full: ready depends only on the registered count
  assign in_ready_o  = (count != (PTR_W+1)'(DEPTH)) & !flush_i;
  assign out_valid_o = (count != '0) & !flush_i;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign count_o     = count;
  assign wr_entry    = '{pc: in_pc_i, inst: in_inst_i, inslot: in_inslot_i,
                         excs: in_excs_i, has_exc: in_has_exc_i};

  assign out_pc_o      = rd_entry.pc;
  assign out_inst_o    = rd_entry.inst;
  assign out_inslot_o  = rd_entry.inslot;
  assign out_excs_o    = rd_entry.excs;
  assign out_has_exc_o = rd_entry.has_exc;

  iq_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // pointers wrap naturally; flush empties the queue and drops same-cycle push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end
endmodule
